// File: rtl/img_demosaic_acpi_g_calc.sv
`default_nettype none
// ============================================================================
// Module   : img_demosaic_acpi_g_calc
// Brief    : ACPI green-plane interpolation; 5x5 Bayer window -> (raw, green).
// Revision : 1.0 - initial release
// ============================================================================
module img_demosaic_acpi_g_calc #(
  parameter int  TAPS      = 1,
  parameter int  TAP_POS   = 0,
  parameter int  CH_BITS   = 10,
  parameter type ch_t      = logic [CH_BITS-1:0],
  parameter int  CALC_BITS = CH_BITS + 6,
  parameter type calc_t    = logic signed [CALC_BITS-1:0]
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cke,
  input  logic [1:0]                       param_phase,
  input  logic                             in_line_first,
  input  logic                             in_pixel_first,
  input  logic [4:0][4:0][CH_BITS-1:0]     in_data,
  output logic [CH_BITS-1:0]               out_raw,
  output logic [CH_BITS-1:0]               out_g
);

  // A signed ch_t sign-extends its all-ones value into the extra MSB.
  localparam ch_t                c_ONES     = '1;
  localparam logic [CH_BITS:0]   c_ONES_EXT = (CH_BITS+1)'(c_ONES);
  localparam logic               c_SIGNED   = c_ONES_EXT[CH_BITS];
  localparam logic               c_TAP_STEP = ((TAPS % 2) != 0);
  localparam logic               c_TAP_OFS  = ((TAP_POS % 2) != 0);
  localparam calc_t              c_MAX      = c_SIGNED ? calc_t'((64'sd1 <<< (CH_BITS-1)) - 64'sd1)
                                                       : calc_t'((64'sd1 <<< CH_BITS) - 64'sd1);
  localparam calc_t              c_MIN      = c_SIGNED ? calc_t'(-(64'sd1 <<< (CH_BITS-1)))
                                                       : calc_t'(64'sd0);

  function automatic calc_t f_ext(input logic [CH_BITS-1:0] v);
    return calc_t'($signed({c_SIGNED & v[CH_BITS-1], v}));
  endfunction

  function automatic calc_t f_abs(input calc_t a);
    return (a < 0) ? -a : a;
  endfunction

  // Corner taps of the window are not needed by the green estimate.
  logic w_unused_window;
  assign w_unused_window = ^in_data;

  // ---------------------------------------------------------------- phase
  logic [1:0] r_phase;
  logic       r_line_bit0;
  logic [1:0] w_phase;
  logic       w_green;

  always_comb begin
    w_phase = r_phase;
    if (in_pixel_first && in_line_first) begin
      w_phase = {param_phase[1], param_phase[0] ^ c_TAP_OFS};
    end else if (in_pixel_first) begin
      w_phase = {~r_phase[1], r_line_bit0};
    end
  end

  assign w_green = w_phase[0] ^ w_phase[1];

  // ---------------------------------------------------------------- taps
  calc_t w_c, w_g21, w_g23, w_g12, w_g32, w_r20, w_r24, w_r02, w_r42;
  assign w_c   = f_ext(in_data[2][2]);
  assign w_g21 = f_ext(in_data[2][1]);
  assign w_g23 = f_ext(in_data[2][3]);
  assign w_g12 = f_ext(in_data[1][2]);
  assign w_g32 = f_ext(in_data[3][2]);
  assign w_r20 = f_ext(in_data[2][0]);
  assign w_r24 = f_ext(in_data[2][4]);
  assign w_r02 = f_ext(in_data[0][2]);
  assign w_r42 = f_ext(in_data[4][2]);

  // ---------------------------------------------------------------- pipeline
  logic [CH_BITS-1:0] r_s0_raw, r_s1_raw, r_s2_raw, r_s3_raw;
  logic               r_s0_green, r_s1_green, r_s2_green, r_s3_green;
  calc_t              r_s0_r, r_s0_hg, r_s0_vg, r_s0_hr, r_s0_vr, r_s0_dgh, r_s0_dgv;
  calc_t              r_s1_grad_h, r_s1_grad_v, r_s1_h, r_s1_v;
  calc_t              r_s2_x;
  calc_t              r_s3_x;
  calc_t              w_r2;
  calc_t              w_clip;

  assign w_r2 = r_s0_r <<< 1;

  always_comb begin
    w_clip = r_s3_x;
    if (r_s3_x < c_MIN) begin
      w_clip = c_MIN;
    end else if (r_s3_x > c_MAX) begin
      w_clip = c_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= 2'b00;
      r_line_bit0 <= 1'b0;
      r_s0_raw    <= '0;
      r_s0_green  <= 1'b0;
      r_s0_r      <= '0;
      r_s0_hg     <= '0;
      r_s0_vg     <= '0;
      r_s0_hr     <= '0;
      r_s0_vr     <= '0;
      r_s0_dgh    <= '0;
      r_s0_dgv    <= '0;
      r_s1_raw    <= '0;
      r_s1_green  <= 1'b0;
      r_s1_grad_h <= '0;
      r_s1_grad_v <= '0;
      r_s1_h      <= '0;
      r_s1_v      <= '0;
      r_s2_raw    <= '0;
      r_s2_green  <= 1'b0;
      r_s2_x      <= '0;
      r_s3_raw    <= '0;
      r_s3_green  <= 1'b0;
      r_s3_x      <= '0;
      out_raw     <= '0;
      out_g       <= '0;
    end else if (cke) begin
      r_phase <= {w_phase[1], w_phase[0] ^ c_TAP_STEP};
      if (in_pixel_first && in_line_first) begin
        r_line_bit0 <= w_phase[0];
      end

      r_s0_raw   <= in_data[2][2];
      r_s0_green <= w_green;
      r_s0_r     <= w_c;
      r_s0_hg    <= w_g21 + w_g23;
      r_s0_vg    <= w_g12 + w_g32;
      r_s0_hr    <= w_r20 + w_r24;
      r_s0_vr    <= w_r02 + w_r42;
      r_s0_dgh   <= f_abs(w_g21 - w_g23);
      r_s0_dgv   <= f_abs(w_g12 - w_g32);

      // H and V carry four times the directional green estimate.
      r_s1_raw    <= r_s0_raw;
      r_s1_green  <= r_s0_green;
      r_s1_grad_h <= r_s0_dgh + f_abs(w_r2 - r_s0_hr);
      r_s1_grad_v <= r_s0_dgv + f_abs(w_r2 - r_s0_vr);
      r_s1_h      <= (r_s0_hg <<< 1) + w_r2 - r_s0_hr;
      r_s1_v      <= (r_s0_vg <<< 1) + w_r2 - r_s0_vr;

      r_s2_raw   <= r_s1_raw;
      r_s2_green <= r_s1_green;
      if (r_s1_grad_h < r_s1_grad_v) begin
        r_s2_x <= r_s1_h <<< 1;
      end else if (r_s1_grad_v < r_s1_grad_h) begin
        r_s2_x <= r_s1_v <<< 1;
      end else begin
        r_s2_x <= r_s1_h + r_s1_v;
      end

      r_s3_raw   <= r_s2_raw;
      r_s3_green <= r_s2_green;
      r_s3_x     <= r_s2_x >>> 3;

      out_raw <= r_s3_raw;
      out_g   <= r_s3_green ? r_s3_raw : CH_BITS'(w_clip);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_demosaic_acpi_g_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_demosaic_acpi_g_calc
// Brief    : Self-checking bench for the ACPI green interpolation stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_demosaic_acpi_g_calc;

  localparam int CH_BITS = 10;
  localparam int LAT     = 5;
  localparam int MAXV    = (1 << CH_BITS) - 1;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic                         cke;
  logic [1:0]                   param_phase;
  logic                         in_line_first;
  logic                         in_pixel_first;
  logic [4:0][4:0][CH_BITS-1:0] in_data;
  logic [CH_BITS-1:0]           out_raw;
  logic [CH_BITS-1:0]           out_g;

  int checks = 0;
  int errors = 0;
  int exp_raw_q[$];
  int exp_g_q[$];
  int col = 0;
  int row = 0;

  img_demosaic_acpi_g_calc dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cke            (cke),
    .param_phase    (param_phase),
    .in_line_first  (in_line_first),
    .in_pixel_first (in_pixel_first),
    .in_data        (in_data),
    .out_raw        (out_raw),
    .out_g          (out_g)
  );

  always #5 clk = ~clk;

  // Reference: green estimate straight from the Adams/Hamilton formulas.
  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int floor_div8(input int a);
    return (a >= 0) ? (a / 8) : -((-a + 7) / 8);
  endfunction

  function automatic int ref_green(input logic [4:0][4:0][CH_BITS-1:0] w);
    int c, gl, gr, gu, gd, rl, rr, ru, rd;
    int grad_h, grad_v, est_h4, est_v4, sum8, g;
    c  = int'(w[2][2]);
    gl = int'(w[2][1]);  gr = int'(w[2][3]);
    gu = int'(w[1][2]);  gd = int'(w[3][2]);
    rl = int'(w[2][0]);  rr = int'(w[2][4]);
    ru = int'(w[0][2]);  rd = int'(w[4][2]);
    grad_h = iabs(gl - gr) + iabs(2 * c - (rl + rr));
    grad_v = iabs(gu - gd) + iabs(2 * c - (ru + rd));
    est_h4 = 2 * (gl + gr) + 2 * c - (rl + rr);
    est_v4 = 2 * (gu + gd) + 2 * c - (ru + rd);
    if (grad_h < grad_v)      sum8 = 2 * est_h4;
    else if (grad_v < grad_h) sum8 = 2 * est_v4;
    else                      sum8 = est_h4 + est_v4;
    g = floor_div8(sum8);
    if (g < 0)    g = 0;
    if (g > MAXV) g = MAXV;
    return g;
  endfunction

  task automatic check_out(input string tag);
    int n, er, eg;
    n = exp_raw_q.size();
    if (n >= LAT) begin
      er = exp_raw_q[n - LAT];
      eg = exp_g_q[n - LAT];
    end else begin
      er = 0;
      eg = 0;
    end
    checks++;
    assert (out_raw === CH_BITS'(er)) else begin
      errors++;
      $error("FAIL %s out_raw observed=%0d expected=%0d", tag, out_raw, er);
    end
    checks++;
    assert (out_g === CH_BITS'(eg)) else begin
      errors++;
      $error("FAIL %s out_g observed=%0d expected=%0d", tag, out_g, eg);
    end
  endtask

  task automatic expect_const(input string tag, input int er, input int eg);
    checks++;
    assert (out_raw === CH_BITS'(er)) else begin
      errors++;
      $error("FAIL %s out_raw observed=%0d expected=%0d", tag, out_raw, er);
    end
    checks++;
    assert (out_g === CH_BITS'(eg)) else begin
      errors++;
      $error("FAIL %s out_g observed=%0d expected=%0d", tag, out_g, eg);
    end
  endtask

  // One clock: drive controls, let the model see the enabled beat, check after.
  task automatic beat(input logic c, input logic lf, input logic pf, input string tag);
    bit green;
    cke            = c;
    in_line_first  = lf;
    in_pixel_first = pf;
    @(posedge clk);
    if (c && reset_n) begin
      if (pf && lf) begin
        row = 0;
        col = 0;
      end else if (pf) begin
        row++;
        col = 0;
      end else begin
        col++;
      end
      green = (param_phase[0] ^ col[0]) ^ (param_phase[1] ^ row[0]);
      exp_raw_q.push_back(int'(in_data[2][2]));
      exp_g_q.push_back(green ? int'(in_data[2][2]) : ref_green(in_data));
    end
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic rand_window();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        in_data[r][c] = CH_BITS'($urandom_range(0, MAXV));
  endtask

  task automatic fill_window(input int v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        in_data[r][c] = CH_BITS'(v);
  endtask

  task automatic set_cross(input int c, input int g21, input int g23, input int g12,
                           input int g32, input int r20, input int r24, input int r02,
                           input int r42);
    rand_window();
    in_data[2][2] = CH_BITS'(c);
    in_data[2][1] = CH_BITS'(g21);
    in_data[2][3] = CH_BITS'(g23);
    in_data[1][2] = CH_BITS'(g12);
    in_data[3][2] = CH_BITS'(g32);
    in_data[2][0] = CH_BITS'(r20);
    in_data[2][4] = CH_BITS'(r24);
    in_data[0][2] = CH_BITS'(r02);
    in_data[4][2] = CH_BITS'(r42);
  endtask

  // Single directed window, flushed through the pipeline with random filler.
  task automatic directed(input string tag, input logic [1:0] pp, input int er, input int eg);
    param_phase = pp;
    beat(1'b1, 1'b1, 1'b1, tag);
    for (int i = 0; i < LAT - 1; i++) begin
      rand_window();
      beat(1'b1, 1'b1, 1'b1, "flush");
    end
    expect_const(tag, er, eg);
  endtask

  task automatic pattern_frame(input int n_lines, input string tag);
    for (int l = 0; l < n_lines; l++)
      for (int p = 0; p < 4; p++)
        beat(1'b1, (l == 0) && (p == 0), p == 0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    cke            = 1'b0;
    param_phase    = 2'b00;
    in_line_first  = 1'b0;
    in_pixel_first = 1'b0;
    fill_window(0);
    repeat (2) @(negedge clk);
    expect_const("reset", 0, 0);
    reset_n = 1'b1;

    // Flat field with a 3-cycle cke stall: first result lands on wall cycle 8.
    param_phase = 2'($urandom_range(0, 3));
    fill_window(512);
    beat(1'b1, 1'b1, 1'b1, "flat");
    beat(1'b1, 1'b0, 1'b0, "flat");
    repeat (3) beat(1'b0, 1'b0, 1'b0, "flat_stall");
    beat(1'b1, 1'b0, 1'b0, "flat");
    beat(1'b1, 1'b0, 1'b0, "flat");
    expect_const("flat_wall7", 0, 0);
    beat(1'b1, 1'b0, 1'b0, "flat");
    expect_const("flat_wall8", 512, 512);
    repeat (4) beat(1'b1, 1'b0, 1'b0, "flat");

    // Directed corner cases.
    set_cross(300, $urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
              $urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
              $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    directed("green_pass", 2'b01, 300, 300);
    set_cross(400, 200, 200, 1000, 0, 400, 400, 400, 400);
    directed("dir_select", 2'b00, 400, 200);
    set_cross(400, 200, 200, 600, 600, 400, 400, 400, 400);
    directed("equal_grad", 2'b00, 400, 400);
    set_cross(1023, 1023, 1023, 1023, 0, 0, 0, 0, 0);
    directed("clip_high", 2'b00, 1023, 1023);
    set_cross(0, 0, 0, 1023, 0, 1023, 1023, 1023, 1023);
    directed("clip_low", 2'b11, 0, 0);

    // Random windows, random cke, 6-pixel lines, new phase per frame.
    for (int f = 0; f < 3; f++) begin
      param_phase = 2'($urandom_range(0, 3));
      for (int i = 0; i < 30; i++) begin
        logic en;
        rand_window();
        en = ($urandom_range(0, 3) != 0);
        beat(en, (i == 0), (i % 6) == 0, "random");
      end
    end

    // Green pattern with 4-pixel lines: centre 800, estimate 400 elsewhere.
    param_phase = 2'b01;
    fill_window(0);
    in_data[2][2] = CH_BITS'(800);
    pattern_frame(3, "pattern");
    beat(1'b1, 1'b0, 1'b1, "pattern");
    beat(1'b1, 1'b0, 1'b0, "pattern");

    // Asynchronous reset mid-line.
    #2;
    reset_n = 1'b0;
    #1;
    expect_const("async_reset", 0, 0);
    exp_raw_q.delete();
    exp_g_q.delete();
    @(negedge clk);
    beat(1'b1, 1'b0, 1'b0, "in_reset");
    beat(1'b1, 1'b1, 1'b1, "in_reset");
    reset_n = 1'b1;
    pattern_frame(3, "pattern_restart");
    repeat (LAT) beat(1'b1, 1'b0, 1'b0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
